image_streamer: RTL and testbench

- Source-side controller for the convolution window buffer.
- Reads a stored feature map (NUM_LINES x LINE_LENGTH pixels) from a synchronous single-port RAM in raster order.
- Drives the window buffer's pixel input and shift-enable.
- Flags each cycle in which the window buffer holds a complete, non-wrapping WINDOW_SIZE x WINDOW_SIZE window, and reports that window's position.
- Sits between the layer's input RAM and window_buffer / conv MAC array; supports downstream back-pressure.

---
 rtl/image_streamer.sv | 99 +++++++++
 tb/tb_image_streamer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/image_streamer.sv
// image_streamer: raster-order RAM reader feeding a window buffer, flagging complete windows.
// Optional IMAGE_STREAMER_STRIDE2_EN: flag only windows at even row and column.
module image_streamer #(
    parameter int DATA_WIDTH  = 32,
    parameter int LINE_LENGTH = 28,
    parameter int NUM_LINES   = 28,
    parameter int WINDOW_SIZE = 3,
    parameter int ADDR_WIDTH  = $clog2(LINE_LENGTH*NUM_LINES)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic                           ready_i,
    output logic                           mem_en_o,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    input  logic [DATA_WIDTH-1:0]          mem_data_i,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic                           enable_o,
    output logic                           window_valid_o,
    output logic [$clog2(NUM_LINES)-1:0]   win_row_o,
    output logic [$clog2(LINE_LENGTH)-1:0] win_col_o,
    output logic                           busy_o,
    output logic                           done_o
);
    localparam int N  = LINE_LENGTH*NUM_LINES;
    localparam int IW = $clog2(N+1);
    localparam int RW = $clog2(NUM_LINES);
    localparam int CW = $clog2(LINE_LENGTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         issue_q, issue_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [RW-1:0]         prow_q, prow_d, win_row_q, win_row_d, rdiff;
    logic [CW-1:0]         pcol_q, pcol_d, win_col_q, win_col_d, cdiff;
    logic                  wv_q, wv_d;
    logic                  advance, issue, eol, last, hit;

    always_comb begin
        advance    = ready_i || !s1_valid_q;
        issue      = state_q == RUN && advance && issue_q < IW'(N);
        mem_en_o   = issue;
        mem_addr_o = issue ? ADDR_WIDTH'(issue_q) : addr_q;
        data_o     = mem_data_i;
        enable_o   = s1_valid_q && ready_i;
        eol        = pcol_q == CW'(LINE_LENGTH-1);
        last       = eol && prow_q == RW'(NUM_LINES-1);
        rdiff      = prow_q - RW'(WINDOW_SIZE-1);
        cdiff      = pcol_q - CW'(WINDOW_SIZE-1);
        hit        = enable_o && prow_q >= RW'(WINDOW_SIZE-1) && pcol_q >= CW'(WINDOW_SIZE-1);
`ifdef IMAGE_STREAMER_STRIDE2_EN
        hit        = hit && !rdiff[0] && !cdiff[0];
`else
        hit        = hit;
`endif
        state_d    = state_q == IDLE ? (start_i ? RUN : IDLE)
                   : state_q == RUN  ? (enable_o && last ? FIN : RUN) : IDLE;
        issue_d    = state_q == IDLE ? '0 : issue_q + IW'(issue);
        addr_d     = mem_addr_o;
        s1_valid_d = advance ? issue : s1_valid_q;
        pcol_d     = state_q == IDLE ? '0 : enable_o ? (eol ? '0 : pcol_q + 1'b1) : pcol_q;
        prow_d     = state_q == IDLE ? '0 : enable_o && eol ? prow_q + 1'b1 : prow_q;
        wv_d       = hit;
        win_row_d  = hit ? rdiff : win_row_q;
        win_col_d  = hit ? cdiff : win_col_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            issue_q    <= '0;
            addr_q     <= '0;
            s1_valid_q <= 1'b0;
            prow_q     <= '0;
            pcol_q     <= '0;
            wv_q       <= 1'b0;
            win_row_q  <= '0;
            win_col_q  <= '0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            addr_q     <= addr_d;
            s1_valid_q <= s1_valid_d;
            prow_q     <= prow_d;
            pcol_q     <= pcol_d;
            wv_q       <= wv_d;
            win_row_q  <= win_row_d;
            win_col_q  <= win_col_d;
        end
    end

    assign window_valid_o = wv_q;
    assign win_row_o      = win_row_q;
    assign win_col_o      = win_col_q;
    assign busy_o         = state_q != IDLE;
    assign done_o         = state_q == FIN;
endmodule

// File: tb/tb_image_streamer.sv
// tb_image_streamer: directed scenarios for image_streamer on small images.
module tb_image_streamer;
`ifdef IMAGE_STREAMER_STRIDE2_EN
    localparam int L = 6, NL = 6;
`else
    localparam int L = 4, NL = 4;
`endif
    localparam int W = 3, DW = 32, AW = $clog2(L*NL), RW = $clog2(NL), CW = $clog2(L);

    logic clk = 0, rst_ni = 0, start_i = 0, ready_i = 1;
    logic mem_en_o, enable_o, window_valid_o, busy_o, done_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_i = '0, data_o;
    logic [RW-1:0] win_row_o;
    logic [CW-1:0] win_col_o;
    logic [DW-1:0] ram [64];

    logic en_a [64], wv_a [64], done_a [64], busy_a [64], men_a [64];
    logic [DW-1:0] dat_a [64];
    logic [AW-1:0] addr_a [64];
    logic [RW-1:0] row_a [64];
    logic [CW-1:0] col_a [64];
    int pass = 0, total = 0;

    image_streamer #(.DATA_WIDTH(DW), .LINE_LENGTH(L), .NUM_LINES(NL), .WINDOW_SIZE(W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .ready_i(ready_i),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .data_o(data_o), .enable_o(enable_o), .window_valid_o(window_valid_o),
        .win_row_o(win_row_o), .win_col_o(win_col_o), .busy_o(busy_o), .done_o(done_o));

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_en_o) mem_data_i <= ram[mem_addr_o];

    // mode: 0 full rate, 1 stall 5..7, 2 alternating ready, 3 second start at 6, 4 reset at 8..9
    task run(input int n, input int mode);
        for (int c = 0; c < n; c++) begin
            start_i = (c == 0) || (mode == 3 && c == 6) || (mode == 4 && c == 12);
            ready_i = mode == 1 ? !(c >= 5 && c <= 7) : mode == 2 ? (c % 2 == 0) : 1'b1;
            if (mode == 4) rst_ni = !(c == 8 || c == 9);
            @(negedge clk);
            en_a[c] = enable_o; wv_a[c] = window_valid_o; done_a[c] = done_o; busy_a[c] = busy_o;
            men_a[c] = mem_en_o; dat_a[c] = data_o; addr_a[c] = mem_addr_o;
            row_a[c] = win_row_o; col_a[c] = win_col_o;
            @(posedge clk); #1;
        end
        start_i = 0; ready_i = 1;
    endtask

    task test_reset;
        rst_ni = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({mem_en_o, enable_o, window_valid_o, busy_o, done_o} !== 5'b0 || mem_addr_o !== '0 ||
            win_row_o !== '0 || win_col_o !== '0)
            $display("FAIL reset_outputs got en=%b sh=%b wv=%b busy=%b done=%b addr=%0d exp all 0",
                     mem_en_o, enable_o, window_valid_o, busy_o, done_o, mem_addr_o);
        else pass++;
        @(posedge clk); #1 rst_ni = 1;
        @(posedge clk); #1;
    endtask

    task test_full_rate(input int mode);
        logic exp_wv;
        run(30, mode);
        total++;
        if (men_a[1] !== 1'b1 || addr_a[1] !== '0) $display("FAIL first_read m%0d got en=%b addr=%0d exp 1/0", mode, men_a[1], addr_a[1]);
        else pass++;
        for (int c = 0; c < 30; c++) begin
            total++;
            if (en_a[c] !== (c >= 2 && c <= 17)) $display("FAIL enable m%0d c=%0d got %b exp %b", mode, c, en_a[c], c >= 2 && c <= 17);
            else pass++;
            if (c >= 2 && c <= 17) begin
                total++;
                if (dat_a[c] !== DW'(c-2)) $display("FAIL data m%0d c=%0d got %0d exp %0d", mode, c, dat_a[c], c-2);
                else pass++;
            end
            exp_wv = c == 13 || c == 14 || c == 17 || c == 18;
            total++;
            if (wv_a[c] !== exp_wv) $display("FAIL wvalid m%0d c=%0d got %b exp %b", mode, c, wv_a[c], exp_wv);
            else pass++;
            if (exp_wv) begin
                total++;
                if (row_a[c] !== RW'(c >= 17) || col_a[c] !== CW'(c == 14 || c == 18))
                    $display("FAIL winpos m%0d c=%0d got (%0d,%0d) exp (%0d,%0d)", mode, c, row_a[c], col_a[c], c >= 17, c == 14 || c == 18);
                else pass++;
            end
            total++;
            if (done_a[c] !== (c == 18) || busy_a[c] !== (c >= 1 && c <= 18))
                $display("FAIL done_busy m%0d c=%0d got %b/%b exp %b/%b", mode, c, done_a[c], busy_a[c], c == 18, c >= 1 && c <= 18);
            else pass++;
        end
    endtask

    task test_stall;
        logic exp_en, exp_wv;
        run(30, 1);
        for (int c = 0; c < 30; c++) begin
            exp_en = (c >= 2 && c <= 4) || (c >= 8 && c <= 20);
            total++;
            if (en_a[c] !== exp_en) $display("FAIL stall_enable c=%0d got %b exp %b", c, en_a[c], exp_en);
            else pass++;
            if (exp_en) begin
                total++;
                if (dat_a[c] !== DW'(c <= 4 ? c-2 : c-5)) $display("FAIL stall_data c=%0d got %0d exp %0d", c, dat_a[c], c <= 4 ? c-2 : c-5);
                else pass++;
            end
            exp_wv = c == 16 || c == 17 || c == 20 || c == 21;
            total++;
            if (wv_a[c] !== exp_wv) $display("FAIL stall_wvalid c=%0d got %b exp %b", c, wv_a[c], exp_wv);
            else pass++;
            total++;
            if (done_a[c] !== (c == 21)) $display("FAIL stall_done c=%0d got %b exp %b", c, done_a[c], c == 21);
            else pass++;
        end
    endtask

    task test_alternating;
        int ne, nw, nd;
        logic [DW-1:0] nxt;
        ne = 0; nw = 0; nd = 0; nxt = 0;
        run(64, 2);
        for (int c = 0; c < 64; c++) begin
            if (en_a[c]) begin
                total++;
                if (dat_a[c] !== nxt) $display("FAIL alt_order c=%0d got %0d exp %0d", c, dat_a[c], nxt);
                else pass++;
                nxt++; ne++;
            end
            nw += int'(wv_a[c]);
            nd += int'(done_a[c]);
        end
        total++;
        if (ne != 16 || nw != 4 || nd != 1) $display("FAIL alt_counts got en=%0d win=%0d done=%0d exp 16/4/1", ne, nw, nd);
        else pass++;
    endtask

    task test_midframe_reset;
        int nd;
        nd = 0;
        run(34, 4);
        total++;
        if (busy_a[7] !== 1'b1) $display("FAIL rst_prebusy got %b exp 1", busy_a[7]);
        else pass++;
        for (int c = 8; c <= 9; c++) begin
            total++;
            if ({men_a[c], en_a[c], wv_a[c], busy_a[c], done_a[c]} !== 5'b0 || addr_a[c] !== '0)
                $display("FAIL rst_outputs c=%0d got %b%b%b%b%b addr=%0d exp 0", c, men_a[c], en_a[c], wv_a[c], busy_a[c], done_a[c], addr_a[c]);
            else pass++;
        end
        for (int c = 8; c <= 29; c++) nd += int'(done_a[c]);
        total++;
        if (nd != 0 || busy_a[12] !== 1'b0) $display("FAIL rst_nodone got done=%0d busy12=%b exp 0/0", nd, busy_a[12]);
        else pass++;
        total++;
        if (men_a[13] !== 1'b1 || addr_a[13] !== '0) $display("FAIL rst_restart got en=%b addr=%0d exp 1/0", men_a[13], addr_a[13]);
        else pass++;
        total++;
        if (en_a[14] !== 1'b1 || dat_a[14] !== '0) $display("FAIL rst_firstpix got en=%b data=%0d exp 1/0", en_a[14], dat_a[14]);
        else pass++;
        total++;
        if (done_a[30] !== 1'b1) $display("FAIL rst_done got %b exp 1", done_a[30]);
        else pass++;
    endtask

    task test_stride2;
        int ne, nw;
        logic exp_wv;
        ne = 0; nw = 0;
        run(45, 0);
        for (int c = 0; c < 45; c++) begin
            ne += int'(en_a[c]);
            exp_wv = c == 17 || c == 19 || c == 29 || c == 31;
            total++;
            if (wv_a[c] !== exp_wv) $display("FAIL s2_wvalid c=%0d got %b exp %b", c, wv_a[c], exp_wv);
            else pass++;
            if (exp_wv) begin
                nw++;
                total++;
                if (row_a[c] !== RW'(c >= 29 ? 2 : 0) || col_a[c] !== CW'(c == 19 || c == 31 ? 2 : 0))
                    $display("FAIL s2_winpos c=%0d got (%0d,%0d)", c, row_a[c], col_a[c]);
                else pass++;
            end
        end
        total++;
        if (ne != 36 || done_a[38] !== 1'b1) $display("FAIL s2_frame got en=%0d done38=%b exp 36/1", ne, done_a[38]);
        else pass++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = DW'(i);
        test_reset;
`ifdef IMAGE_STREAMER_STRIDE2_EN
        test_stride2;
`else
        test_full_rate(0);
        test_stall;
        test_alternating;
        test_full_rate(3);
        test_midframe_reset;
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
